// File: rtl/seven_seg_capture.sv
// Reads a multiplexed active-low 7-segment bus, waits for each digit to be stable, then decodes and assembles a hex word.
// Latency: a commit is visible after edge E0+STABLE_CYCLES-1 (E0 = first sample edge); no backpressure, every cycle is sampled.
module seven_seg_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3,
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [0:6]          seg_in,
  input  logic [DIGITS-1:0]   dig_en,
  output logic [4*DIGITS-1:0] value,
  output logic [DIGITS-1:0]   digit_ok,
  output logic                frame_valid,
  output logic                bad_pattern,
  output logic [DW-1:0]       bad_digit
);

  typedef enum logic [1:0] {IDLE, COUNTING, LOCKED} state_t;

  localparam logic [7:0]        N         = 8'(STABLE_CYCLES);
  localparam logic [0:6]        SEG_BLANK = 7'b1111111;
  localparam logic [DIGITS-1:0] ALL_SEEN  = '1;

  state_t              state, state_nx;
  logic [7:0]          run, run_nx;
  logic [0:6]          prev_seg;
  logic [DIGITS-1:0]   prev_en;
  logic [DIGITS-1:0]   seen, seen_nx;
  logic                qualified, same, commit;
  logic [4:0]          decoded;
  logic [DW-1:0]       idx;
  logic [4*DIGITS-1:0] value_nx;
  logic [DIGITS-1:0]   ok_nx;
  logic                fv_nx, bp_nx;
  logic [DW-1:0]       bd_nx;

  // Bit 4 flags a recognised code; bits 3:0 carry the nibble.
  function automatic logic [4:0] decode(input logic [0:6] s);
    case (s)
      7'b0000001: decode = {1'b1, 4'h0};
      7'b1001111: decode = {1'b1, 4'h1};
      7'b0010010: decode = {1'b1, 4'h2};
      7'b0000110: decode = {1'b1, 4'h3};
      7'b1001100: decode = {1'b1, 4'h4};
      7'b0100100: decode = {1'b1, 4'h5};
      7'b0100000: decode = {1'b1, 4'h6};
      7'b0001111: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0001100: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b1100000: decode = {1'b1, 4'hB};
      7'b0110001: decode = {1'b1, 4'hC};
      7'b1000010: decode = {1'b1, 4'hD};
      7'b0110000: decode = {1'b1, 4'hE};
      7'b0111000: decode = {1'b1, 4'hF};
      default:    decode = 5'b0;
    endcase
  endfunction

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_en[i]) idx = DW'(i);
    end
  end

  // Run tracking: the state mirrors where run sits relative to the threshold.
  always_comb begin
    decoded   = decode(seg_in);
    qualified = (dig_en != '0) && ((dig_en & (dig_en - DIGITS'(1))) == '0);
    same      = (seg_in == prev_seg) && (dig_en == prev_en);

    if (!qualified)
      run_nx = '0;
    else if (same && run != '0)
      run_nx = (run >= N) ? N : run + 8'd1;
    else
      run_nx = 8'd1;

    if (run_nx == '0)
      state_nx = IDLE;
    else if (run_nx == N)
      state_nx = LOCKED;
    else
      state_nx = COUNTING;

    // A run already LOCKED on the same sample has committed once already.
    commit = qualified && (run_nx == N) && !(same && state == LOCKED);
  end

  always_comb begin
    value_nx = value;
    ok_nx    = digit_ok;
    seen_nx  = seen;
    bd_nx    = bad_digit;
    fv_nx    = 1'b0;
    bp_nx    = 1'b0;
    if (commit) begin
      if (decoded[4]) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (dig_en[i]) value_nx[4*i +: 4] = decoded[3:0];
        end
        ok_nx = digit_ok | dig_en;
        if ((seen | dig_en) == ALL_SEEN) begin
          seen_nx = '0;
          fv_nx   = 1'b1;
        end else begin
          seen_nx = seen | dig_en;
        end
      end else begin
        ok_nx   = digit_ok & ~dig_en;
        seen_nx = seen & ~dig_en;
        bp_nx   = 1'b1;
        bd_nx   = idx;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      run         <= '0;
      prev_seg    <= SEG_BLANK;
      prev_en     <= '0;
      seen        <= '0;
      value       <= '0;
      digit_ok    <= '0;
      frame_valid <= 1'b0;
      bad_pattern <= 1'b0;
      bad_digit   <= '0;
    end else begin
      state       <= state_nx;
      run         <= run_nx;
      prev_seg    <= seg_in;
      prev_en     <= dig_en;
      seen        <= seen_nx;
      value       <= value_nx;
      digit_ok    <= ok_nx;
      frame_valid <= fv_nx;
      bad_pattern <= bp_nx;
      bad_digit   <= bd_nx;
    end
  end

  pulse_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(frame_valid && bad_pattern));

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Display-side reader for the multiplexed 7-segment bus. It samples the active-low segment lines and the one-hot digit strobes, and waits until each digit's pattern has been stable for a programmable number of cycles. It then decodes the pattern back to its 4-bit hex value and assembles all digits into one word. It sits between the display drivers and the test/readback logic, so the processor's displayed output can be checked or logged without a human reading the board.

## Interface
- `DIGITS`, default 4: number of multiplexed digits; 1..8.
- `STABLE_CYCLES`, default 3: consecutive identical samples required before a digit is committed; 1..255.
- `clock` input, 1 bit: single clock; all state changes on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `seg_in` input, [0:6]: segment lines, active-low; bit 0 = a … bit 6 = g.
- `dig_en` input, [DIGITS-1:0]: digit strobes, active-high, one-hot; bit i selects digit i.
- `value` output, [4*DIGITS-1:0]: assembled nibbles; digit i occupies bits [4i+3:4i].
- `digit_ok` output, [DIGITS-1:0]: bit i set when slot i holds a validly decoded nibble.
- `frame_valid` output, 1 bit: one-cycle pulse when every digit has been validly committed since the last pulse.
- `bad_pattern` output, 1 bit: one-cycle pulse on commit of an undecodable pattern.
- `bad_digit` output, max(1, ceil(log2 DIGITS)) bits: index of the digit that caused the last `bad_pattern`; holds its value until the next one.

## Operation
- Decode table (seg_in a..g → nibble):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3
  - 1001100→4, 0100100→5, 0100000→6, 0001111→7
  - 0000000→8, 0001100→9, 0001000→A, 1100000→b
  - 0110001→C, 1000010→d, 0110000→E, 0111000→F
  - Any other code is invalid, including all-off 1111111.
- Sample registers `prev_seg`/`prev_en` and a run counter `run` (saturating at STABLE_CYCLES) are updated every cycle.
- Sample qualification:
  - A sample is qualified when `dig_en` is exactly one-hot.
  - `dig_en` = 0 (blanking) or multi-hot: the sample is unqualified, `run` clears, and no commit happens.
- Run counting: if the qualified sample equals the previous sample (both `seg_in` and `dig_en`), `run` increments, saturating. Otherwise `run` restarts at 1.
- Commit condition: the edge on which `run` first reaches STABLE_CYCLES. Exactly one commit per stable run; a pattern held indefinitely never re-commits.
- Commit, valid code:
  - Write the nibble into slot i and set `digit_ok[i]`.
  - Set bit i of the internal `seen` mask.
- Commit, invalid code:
  - Slot i is unchanged and `digit_ok[i]` clears.
  - `bad_pattern` pulses and `bad_digit` ← i.
  - `seen[i]` clears.
- Frame completion: when a valid commit makes `seen` all-ones, `frame_valid` pulses on that same edge and `seen` clears to 0.
- Re-commit of a digit already in `seen`: overwrites the value and does not double-count.
- State machine per run, for the single active strobe:
  - IDLE (`run`=0) → COUNTING (1 ≤ `run` < STABLE_CYCLES) → LOCKED (`run` = STABLE_CYCLES).
  - Any change or unqualified sample returns to IDLE or restarts COUNTING.

## Timing
- Reset values: `value` = 0, `digit_ok` = 0, `frame_valid` = 0, `bad_pattern` = 0, `bad_digit` = 0, `seen` = 0, `run` = 0, and `prev_*` = blank.
- Reset asserted mid-run discards the run. After reset, a held pattern needs a full STABLE_CYCLES of fresh samples.
- Latency: the first sample of a pattern is taken at edge E0. Outputs reflect the commit after edge E0+STABLE_CYCLES-1 (N=3: visible after the third sampling edge). With N=1, commit on the first sample.
- `frame_valid` and `bad_pattern` are high for exactly one cycle. They are never both high on the same edge.
- A strobe change on the edge where `run` would reach N is a new run; no commit.
- No input synchronisation: inputs are in the `clock` domain.

## Test plan
- Reset, then hold `dig_en`=0001 with `seg_in`=0000110 for 3 cycles.
  - Required: `value[3:0]`=3 and `digit_ok`=0001.
  - No `frame_valid` pulse.
- Drive digits 0..3 in turn with 0000001, 1001111, 0010010, 0000110, 3 cycles each.
  - Required: `value`=16'h3210 and `digit_ok`=1111.
  - Required: a single `frame_valid` pulse on the digit-3 commit edge.
- Hold digit 2 at 1111111 for 3 cycles after a frame.
  - Required: `bad_pattern` pulse, `bad_digit`=2, `digit_ok[2]`=0, and `value[11:8]` unchanged.
- Glitch test: digit 1 with 0001000 for 2 cycles, then 1100000 for 3 cycles.
  - Required: only B committed (`value[7:4]`=B).
  - Required: a single commit, with no commit for A.
- Multi-hot `dig_en`=0011 held for 10 cycles, and a pattern held for 20 cycles.
  - Multi-hot required: no commit.
  - Held pattern required: exactly one commit.
- Assert `reset` on cycle 2 of a 3-cycle run.
  - Required: all outputs are 0 after the reset edge.
  - Required: the pattern re-commits only 3 cycles after reset deasserts.
